dcache_ecc_scrub: RTL and testbench



---
 rtl/dcache_ecc_scrub.sv | 202 ++++++++++++++++++++
 tb/tb_dcache_ecc_scrub.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ecc_scrub.sv
// dcache_ecc_scrub: one-cycle Hsiao SECDED decode for a data-cache hit path,
// with saturating error counters and an optional write-back scrub request.
// Optional feature macro: DCACHE_ECC_SCRUB_EN (scrub FSM present when defined).
// Codeword layout: {check[ECC_BITS-1:0], data[DATA_WIDTH-1:0]}.
// H matrix data columns: all weight-3 ECC_BITS-bit values in ascending order,
// then weight-5, weight-7, ... until DATA_WIDTH columns are filled; check-bit
// columns are the unit vectors.
module dcache_ecc_scrub #(
    parameter int DATA_WIDTH = 128,
    parameter int ECC_BITS   = 9,
    parameter int IDX_WIDTH  = 12,
    parameter int NUM_WAYS   = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int CODE_WIDTH = DATA_WIDTH + ECC_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_valid_i,
    input  logic [IDX_WIDTH-1:0]  rd_idx_i,
    input  logic [NUM_WAYS-1:0]   rd_way_i,
    input  logic [CODE_WIDTH-1:0] rd_code_i,
    input  logic                  wr_valid_i,
    input  logic [IDX_WIDTH-1:0]  wr_idx_i,
    input  logic [NUM_WAYS-1:0]   wr_way_i,
    output logic                  data_valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  err_single_o,
    output logic                  err_double_o,
    output logic                  scrub_req_o,
    input  logic                  scrub_gnt_i,
    output logic [IDX_WIDTH-1:0]  scrub_idx_o,
    output logic [NUM_WAYS-1:0]   scrub_way_o,
    output logic [CODE_WIDTH-1:0] scrub_code_o,
    output logic [CNT_WIDTH-1:0]  cnt_single_o,
    output logic [CNT_WIDTH-1:0]  cnt_double_o,
    input  logic                  cnt_clr_i
);

    function automatic logic [DATA_WIDTH-1:0][ECC_BITS-1:0] gen_h();
        logic [DATA_WIDTH-1:0][ECC_BITS-1:0] h;
        int n;
        int ones;
        h = '0;
        n = 0;
        for (int wt = 3; wt <= ECC_BITS; wt += 2) begin
            for (int v = 0; v < (1 << ECC_BITS); v++) begin
                ones = 0;
                for (int b = 0; b < ECC_BITS; b++) ones += (v >> b) & 1;
                if (ones == wt && n < DATA_WIDTH) begin
                    h[n] = ECC_BITS'(v);
                    n++;
                end
            end
        end
        return h;
    endfunction

    localparam logic [DATA_WIDTH-1:0][ECC_BITS-1:0] H = gen_h();

    function automatic logic [ECC_BITS-1:0] enc(input logic [DATA_WIDTH-1:0] d);
        logic [ECC_BITS-1:0] c;
        c = '0;
        for (int j = 0; j < DATA_WIDTH; j++) if (d[j]) c ^= H[j];
        return c;
    endfunction

    logic [ECC_BITS-1:0]   syn;
    logic [DATA_WIDTH-1:0] corr;
    logic                  hit, is_single, is_double;

    // Syndrome decode: locate a matching column and flip it back
    always_comb begin
        syn  = rd_code_i[CODE_WIDTH-1:DATA_WIDTH] ^ enc(rd_code_i[DATA_WIDTH-1:0]);
        corr = rd_code_i[DATA_WIDTH-1:0];
        hit  = 1'b0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            if (syn == H[j]) begin
                corr[j] = ~corr[j];
                hit     = 1'b1;
            end
        end
        for (int i = 0; i < ECC_BITS; i++)
            if (syn == (ECC_BITS'(1) << i)) hit = 1'b1;
        is_single = (syn != '0) && hit;
        is_double = (syn != '0) && !hit;
    end

    logic                  data_valid_q, data_valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_single_q, err_single_d;
    logic                  err_double_q, err_double_d;
    logic [CNT_WIDTH-1:0]  cnt_single_q, cnt_single_d;
    logic [CNT_WIDTH-1:0]  cnt_double_q, cnt_double_d;
    logic                  new_single, new_double;

    // Response register inputs and saturating counters (clear has priority)
    always_comb begin
        new_single   = rd_valid_i && is_single;
        new_double   = rd_valid_i && is_double;
        data_valid_d = rd_valid_i;
        err_single_d = new_single;
        err_double_d = new_double;
        data_d       = data_q;
        if (rd_valid_i) data_d = is_double ? rd_code_i[DATA_WIDTH-1:0] : corr;
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        if (cnt_clr_i) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
        end else begin
            if (new_single && !(&cnt_single_q)) cnt_single_d = cnt_single_q + CNT_WIDTH'(1);
            if (new_double && !(&cnt_double_q)) cnt_double_d = cnt_double_q + CNT_WIDTH'(1);
        end
    end

    // Response and counter state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_valid_q <= 1'b0;
            data_q       <= '0;
            err_single_q <= 1'b0;
            err_double_q <= 1'b0;
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            err_single_q <= err_single_d;
            err_double_q <= err_double_d;
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

    assign data_valid_o = data_valid_q;
    assign data_o       = data_q;
    assign err_single_o = err_single_q;
    assign err_double_o = err_double_q;
    assign cnt_single_o = cnt_single_q;
    assign cnt_double_o = cnt_double_q;

`ifdef DCACHE_ECC_SCRUB_EN
    typedef enum logic {IDLE, REQ} state_e;

    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  scrub_idx_q, scrub_idx_d;
    logic [NUM_WAYS-1:0]   scrub_way_q, scrub_way_d;
    logic [CODE_WIDTH-1:0] scrub_code_q, scrub_code_d;
    logic                  cancel, req, slot_free;

    // Scrub FSM: a colliding write kills the pending request; a free slot
    // (idle, granted or cancelled) takes the newest corrected line
    always_comb begin
        state_d      = state_q;
        scrub_idx_d  = scrub_idx_q;
        scrub_way_d  = scrub_way_q;
        scrub_code_d = scrub_code_q;
        cancel       = (state_q == REQ) && wr_valid_i &&
                       (wr_idx_i == scrub_idx_q) && (wr_way_i == scrub_way_q);
        req          = (state_q == REQ) && !cancel;
        slot_free    = !req || scrub_gnt_i;
        if (slot_free) begin
            if (new_single) begin
                state_d      = REQ;
                scrub_idx_d  = rd_idx_i;
                scrub_way_d  = rd_way_i;
                scrub_code_d = {enc(corr), corr};
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Scrub state and payload
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            scrub_idx_q  <= '0;
            scrub_way_q  <= '0;
            scrub_code_q <= '0;
        end else begin
            state_q      <= state_d;
            scrub_idx_q  <= scrub_idx_d;
            scrub_way_q  <= scrub_way_d;
            scrub_code_q <= scrub_code_d;
        end
    end

    assign scrub_req_o  = req;
    assign scrub_idx_o  = scrub_idx_q;
    assign scrub_way_o  = scrub_way_q;
    assign scrub_code_o = scrub_code_q;
`else
    logic unused_scrub;
    assign unused_scrub = ^{scrub_gnt_i, wr_valid_i, wr_idx_i, wr_way_i};
    assign scrub_req_o  = 1'b0;
    assign scrub_idx_o  = '0;
    assign scrub_way_o  = '0;
    assign scrub_code_o = '0;
`endif

endmodule

// File: tb/tb_dcache_ecc_scrub.sv
// Self-checking bench for dcache_ecc_scrub. The reference model knows how
// many bits it flipped in each codeword, so expected flags/data follow from
// that directly; scrub behaviour is tracked as a single pending slot.
module tb_dcache_ecc_scrub;
    localparam int DW  = 128;
    localparam int EB  = 9;
    localparam int IW  = 12;
    localparam int NW  = 8;
    localparam int CW  = 16;
    localparam int CDW = DW + EB;

    logic           clk_i, rst_ni;
    logic           rd_valid_i;
    logic [IW-1:0]  rd_idx_i;
    logic [NW-1:0]  rd_way_i;
    logic [CDW-1:0] rd_code_i;
    logic           wr_valid_i;
    logic [IW-1:0]  wr_idx_i;
    logic [NW-1:0]  wr_way_i;
    logic           data_valid_o;
    logic [DW-1:0]  data_o;
    logic           err_single_o, err_double_o;
    logic           scrub_req_o, scrub_gnt_i;
    logic [IW-1:0]  scrub_idx_o;
    logic [NW-1:0]  scrub_way_o;
    logic [CDW-1:0] scrub_code_o;
    logic [CW-1:0]  cnt_single_o, cnt_double_o;
    logic           cnt_clr_i;

    dcache_ecc_scrub #(.DATA_WIDTH(DW), .ECC_BITS(EB), .IDX_WIDTH(IW),
                       .NUM_WAYS(NW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rd_valid_i(rd_valid_i), .rd_idx_i(rd_idx_i), .rd_way_i(rd_way_i),
        .rd_code_i(rd_code_i),
        .wr_valid_i(wr_valid_i), .wr_idx_i(wr_idx_i), .wr_way_i(wr_way_i),
        .data_valid_o(data_valid_o), .data_o(data_o),
        .err_single_o(err_single_o), .err_double_o(err_double_o),
        .scrub_req_o(scrub_req_o), .scrub_gnt_i(scrub_gnt_i),
        .scrub_idx_o(scrub_idx_o), .scrub_way_o(scrub_way_o),
        .scrub_code_o(scrub_code_o),
        .cnt_single_o(cnt_single_o), .cnt_double_o(cnt_double_o),
        .cnt_clr_i(cnt_clr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0][EB-1:0] hm;

    // model state
    bit             e_valid, e_s, e_d;
    logic [DW-1:0]  e_data;
    logic [CW-1:0]  c_s, c_d;
    bit             pend;
    logic [IW-1:0]  p_idx;
    logic [NW-1:0]  p_way;
    logic [CDW-1:0] p_code;

    function automatic void build_h();
        int n = 0;
        for (int wt = 3; wt <= EB; wt += 2)
            for (int v = 0; v < 512; v++) begin
                logic [EB-1:0] vv = EB'(v);
                if ($countones(vv) == wt && n < DW) begin
                    hm[n] = vv;
                    n++;
                end
            end
    endfunction

    function automatic logic [EB-1:0] enc(input logic [DW-1:0] d);
        logic [EB-1:0] c = '0;
        for (int j = 0; j < DW; j++) if (d[j]) c ^= hm[j];
        return c;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One clock: check registered outputs, drive, check combinational scrub,
    // advance the model, step to the next falling edge.
    task automatic cycle(input bit rv, input logic [IW-1:0] idx, input logic [NW-1:0] way,
                         input logic [DW-1:0] dat, input int nflip, input int f1, input int f2,
                         input bit wv, input logic [IW-1:0] widx, input logic [NW-1:0] wway,
                         input bit gnt, input bit clr);
        logic [CDW-1:0] code;
        bit req_e, single_now;
        chk("data_valid", data_valid_o, e_valid);
        chk("err_single", err_single_o, e_s);
        chk("err_double", err_double_o, e_d);
        if (e_valid) chk("data", data_o, e_data);
        chk("cnt_single", cnt_single_o, c_s);
        chk("cnt_double", cnt_double_o, c_d);
        code = {enc(dat), dat};
        if (nflip >= 1) code[f1] = ~code[f1];
        if (nflip == 2) code[f2] = ~code[f2];
        rd_valid_i = rv; rd_idx_i = idx; rd_way_i = way; rd_code_i = code;
        wr_valid_i = wv; wr_idx_i = widx; wr_way_i = wway;
        scrub_gnt_i = gnt; cnt_clr_i = clr;
        #1;
`ifdef DCACHE_ECC_SCRUB_EN
        req_e = pend && !(wv && widx == p_idx && wway == p_way);
        chk("scrub_req", scrub_req_o, req_e);
        if (req_e) begin
            chk("scrub_idx", scrub_idx_o, p_idx);
            chk("scrub_way", scrub_way_o, p_way);
            chk("scrub_code", scrub_code_o, p_code);
        end
`else
        req_e = 1'b0;
        chk("scrub_req_off", scrub_req_o, 0);
        chk("scrub_pay_off", {scrub_idx_o, scrub_way_o, scrub_code_o}, 0);
`endif
        single_now = rv && nflip == 1;
        if (clr) begin
            c_s = '0; c_d = '0;
        end else begin
            if (single_now && c_s != '1) c_s++;
            if (rv && nflip == 2 && c_d != '1) c_d++;
        end
`ifdef DCACHE_ECC_SCRUB_EN
        if (!req_e || gnt) begin
            pend = single_now;
            if (single_now) begin
                p_idx = idx; p_way = way; p_code = {enc(dat), dat};
            end
        end
`endif
        e_valid = rv;
        e_s = single_now;
        e_d = rv && nflip == 2;
        if (rv) e_data = (nflip == 2) ? code[DW-1:0] : dat;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        chk("rst_valid", data_valid_o, 0);
        chk("rst_errs", {err_single_o, err_double_o}, 0);
        chk("rst_data", data_o, 0);
        chk("rst_req", scrub_req_o, 0);
        chk("rst_scrub_pay", {scrub_idx_o, scrub_way_o, scrub_code_o}, 0);
        chk("rst_cnts", {cnt_single_o, cnt_double_o}, 0);
        e_valid = 0; e_s = 0; e_d = 0; c_s = '0; c_d = '0; pend = 0;
        rd_valid_i = 0; wr_valid_i = 0; scrub_gnt_i = 0; cnt_clr_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    logic [DW-1:0] a5;

    initial begin
        rst_ni = 1'b0;
        rd_valid_i = 0; rd_idx_i = '0; rd_way_i = '0; rd_code_i = '0;
        wr_valid_i = 0; wr_idx_i = '0; wr_way_i = '0;
        scrub_gnt_i = 0; cnt_clr_i = 0;
        e_data = '0; p_idx = '0; p_way = '0; p_code = '0;
        build_h();
        // pin the code construction itself
        chk("h_col0", hm[0], 9'h007);
        chk("h_col1", hm[1], 9'h00B);
        chk("h_col83", hm[83], 9'h1C0);
        chk("h_col84", hm[84], 9'h01F);
        a5 = {16{8'hA5}};
        @(negedge clk_i);
        do_reset();

        // clean read
        cycle(1, 12'h001, 8'h01, a5, 0, 0, 0, 0, '0, '0, 0, 0);
        chk("a5_lit", data_o, {16{8'hA5}});
        chk("a5_flags", {err_single_o, err_double_o}, 0);

        // single error on data bit 37, grant after 3 cycles
        cycle(1, 12'h010, 8'h04, a5, 1, 37, 0, 0, '0, '0, 0, 0);
        chk("b37_single", err_single_o, 1);
        chk("b37_cnt", cnt_single_o, 1);
        chk("b37_data", data_o, {16{8'hA5}});
`ifdef DCACHE_ECC_SCRUB_EN
        chk("b37_req", scrub_req_o, 1);
        chk("b37_pay", {scrub_idx_o, scrub_way_o}, {12'h010, 8'h04});
`endif
        idle(3);
        cycle(0, '0, '0, '0, 0, 0, 0, 0, '0, '0, 1, 0);
        chk("gnt_idle", scrub_req_o, 0);

        // double error on bits 3 and 90
        cycle(1, 12'h020, 8'h02, a5, 2, 3, 90, 0, '0, '0, 0, 0);
        chk("dbl_flag", err_double_o, 1);
        chk("dbl_cnt", cnt_double_o, 1);
        chk("dbl_noreq", scrub_req_o, 0);

        // write collision cancels pending scrub
        cycle(1, 12'h010, 8'h04, a5, 1, 100, 0, 0, '0, '0, 0, 0);
        cycle(0, '0, '0, '0, 0, 0, 0, 1, 12'h010, 8'h04, 0, 0);
        idle(1);

        // check-bit single error and grant+new error in the same cycle
        cycle(1, 12'h030, 8'h08, a5, 1, DW + 4, 0, 0, '0, '0, 0, 0);
        cycle(1, 12'h031, 8'h10, ~a5, 1, 5, 0, 0, '0, '0, 1, 0);
        cycle(1, 12'h032, 8'h20, a5, 1, 6, 0, 0, '0, '0, 0, 0);
        idle(2);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            logic [DW-1:0] d;
            logic [IW-1:0] idx, widx;
            logic [NW-1:0] way, wway;
            int nf, f1, f2;
            bit wv;
            d   = {$urandom, $urandom, $urandom, $urandom};
            idx = IW'($urandom);
            way = NW'(1) << $urandom_range(NW - 1);
            nf  = $urandom_range(2);
            f1  = $urandom_range(CDW - 1);
            f2  = $urandom_range(CDW - 1);
            while (f2 == f1) f2 = $urandom_range(CDW - 1);
            wv   = $urandom_range(1);
            widx = IW'($urandom);
            wway = NW'(1) << $urandom_range(NW - 1);
            if (pend && $urandom_range(2) == 0) begin
                widx = p_idx; wway = p_way;
            end
            cycle($urandom_range(3) != 0, idx, way, d, nf, f1, f2, wv, widx, wway,
                  $urandom_range(3) == 0, $urandom_range(49) == 0);
        end

        // counter saturation, then clear racing an increment
        cycle(0, '0, '0, '0, 0, 0, 0, 0, '0, '0, 0, 1);
        for (int k = 0; k < 65537; k++)
            cycle(1, 12'h040, 8'h01, a5, 1, k % CDW, 0, 0, '0, '0, 1, 0);
        chk("sat_lit", cnt_single_o, 16'hFFFF);
        cycle(1, 12'h041, 8'h01, a5, 1, 9, 0, 0, '0, '0, 0, 1);
        chk("clr_lit", cnt_single_o, 0);

        // reset while a scrub is pending
        cycle(1, 12'h050, 8'h80, a5, 1, 50, 0, 0, '0, '0, 0, 0);
        do_reset();
        idle(4);
        chk("post_rst_req", scrub_req_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
